fp_unpack_stage: RTL and testbench
==================================

# fp_unpack_stage

Front-end pipeline of the floating-point unit: the decode counterpart to the final normalize/pack stage. It takes raw IEEE-754 single-precision operand vectors from operand fetch and does several jobs per lane:
- splits each operand into sign, exponent and significand, restoring the hidden bit;
- classifies special values;
- for add/sub/compare, orders and aligns the operands with guard/round/sticky bits;
- for multiply, forms the biased product exponent.

It is a fixed two-stage, non-stalling pipeline feeding the adder and multiplier datapath stages.

## Interface
- LANES, 16, number of vector lanes.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- of_instruction_valid  in  1  operands valid this cycle.
- of_op  in  2  0=ADD, 1=SUB, 2=MUL, 3=CMP (compare uses subtract).
- of_operand1, of_operand2  in  LANES×32  raw single-precision operands.
- of_mask_value  in  LANES  lane enable, passed through.
- of_thread_idx  in  2  passed through.
- fx2_instruction_valid  out  1  outputs valid.
- fx2_op, fx2_mask_value, fx2_thread_idx  out  2/LANES/2  delayed copies.
- fx2_add_exponent  out  LANES×8  exponent of the larger-magnitude operand.
- fx2_add_significand_large, fx2_add_significand_small  out  LANES×27  aligned significands. Bit layout is {hidden, frac[22:0], guard, round, sticky}.
- fx2_logical_subtract  out  LANES  effective operation is a subtraction.
- fx2_add_result_sign  out  LANES  sign of the add result.
- fx2_mul_exponent  out  LANES×8  biased product exponent.
- fx2_mul_significand1, fx2_mul_significand2  out  LANES×24  {hidden, frac}.
- fx2_mul_sign  out  LANES  product sign.
- fx2_result_is_inf, fx2_result_is_nan  out  LANES  special-result flags for the selected op.

## Operation

Stage 1 (registered), per lane and per operand:
- sign = bit 31; exp = bits 30:23; frac = bits 22:0.
- hidden = (exp != 0).
- effective exponent = (exp == 0) ? 1 : exp.
- Classes:
  - zero: exp==0 && frac==0;
  - inf: exp==255 && frac==0;
  - nan: exp==255 && frac!=0.
- For SUB and CMP, operand 2 sign is inverted here.

Stage 2 (registered), add path:
- Magnitude compare on {effective exponent, hidden, frac}. If operand 2 is strictly larger, swap; ties keep operand 1 as the large operand.
- shift = exp_large − exp_small.
- small = {hidden, frac, 3'b0} >> shift. Sticky (bit 0) = OR of every bit shifted out, ORed with the previous bit 0.
- shift ≥ 27: small = {26'b0, (small operand nonzero)}.
- logical_subtract = sign_large XOR sign_small.
- result_sign = sign_large, except when the magnitudes are exactly equal with logical_subtract, which gives 0.

Stage 2 (registered), multiply path:
- sum = exp1_eff + exp2_eff − 127, computed in 10-bit signed arithmetic.
- sum ≥ 255: is_inf = 1, mul_exponent = 255.
- sum ≤ 0: underflow. Flush to zero: mul_exponent = 0, both significands = 0.
- mul_sign = sign1 XOR sign2.
- If either operand is zero, both significands are 0 and mul_exponent is 0.

Special flags:
- ADD/SUB/CMP:
  - nan = either operand nan, or (both inf && logical_subtract);
  - inf = either operand inf && !nan.
- MUL:
  - nan = either operand nan, or (inf && other operand zero);
  - inf = (either operand inf, or overflow) && !nan.
- When nan is set, all other numeric outputs are don't-care.

Masked lanes:
- Lanes are computed regardless of mask.
- The mask only travels with the instruction.

## Timing
- Latency is 2 cycles, valid in to fx2_instruction_valid.
- Throughput is one instruction per cycle, with no back-pressure and no stall input.
- Back-to-back instructions must not interfere with each other.
- Both stage registers update every cycle. Valid bits follow of_instruction_valid.
- Data registers may hold stale values while valid = 0.
- Reset values: every output 0, including fx2_instruction_valid and all flags.
- Reset asserted mid-operation clears both stage valid bits at the next edge. Instructions in flight are discarded and never appear at the output.
- First valid output after reset deasserts: 2 cycles after the first valid input.

## Test plan
- ADD 0x3f800000 + 0x3f800000 (1.0 + 1.0) → at cycle +2:
  - add_exponent = 127;
  - both significands = 0x4000000;
  - logical_subtract = 0; sign = 0; no flags.
- SUB 0x3f800000 − 0x3f800000 → logical_subtract = 1, result_sign = 0, both significands = 0x4000000.
- ADD 0x4b800000 + 0x3f800000 (2^24 + 1) → add_exponent = 151, small = 0x0000004 (guard set). Then ADD 0x4e800000 + 0x3f800000 (shift 30) → small = 0x0000001 (sticky only).
- MUL 0x3fc00000 × 0x40000000 (1.5 × 2.0) → mul_exponent = 128, sig1 = 0xC00000, sig2 = 0x800000, sign = 0. Then MUL 0x7f000000 × 0x7f000000 → is_inf = 1.
- Specials:
  - ADD 0x7f800000 + 0xff800000 → is_nan = 1;
  - MUL 0x7f800000 × 0x00000000 → is_nan = 1;
  - ADD 0x7fc00000 + 1.0 → is_nan = 1;
  - ADD 0x7f800000 + 1.0 → is_inf = 1, sign = 0.
- Stream 5 back-to-back instructions, then assert reset for one cycle while 2 are in flight → valid drops the cycle after reset and every output reads 0. Instructions issued after reset emerge with 2-cycle latency and correct data.

Source files
------------

// File: rtl/fp_unpack_stage.sv
// fp_unpack_stage: two-stage FPU front end. Stage 1 splits and classifies
// IEEE-754 single-precision operands. Stage 2 orders and aligns them for the
// adder, forms the biased product exponent for the multiplier, and raises the
// special-result flags for the selected operation.
module fp_unpack_stage #(
  parameter int LANES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    of_instruction_valid,
  input  logic [1:0]              of_op,
  input  logic [LANES-1:0][31:0]  of_operand1,
  input  logic [LANES-1:0][31:0]  of_operand2,
  input  logic [LANES-1:0]        of_mask_value,
  input  logic [1:0]              of_thread_idx,
  output logic                    fx2_instruction_valid,
  output logic [1:0]              fx2_op,
  output logic [LANES-1:0]        fx2_mask_value,
  output logic [1:0]              fx2_thread_idx,
  output logic [LANES-1:0][7:0]   fx2_add_exponent,
  output logic [LANES-1:0][26:0]  fx2_add_significand_large,
  output logic [LANES-1:0][26:0]  fx2_add_significand_small,
  output logic [LANES-1:0]        fx2_logical_subtract,
  output logic [LANES-1:0]        fx2_add_result_sign,
  output logic [LANES-1:0][7:0]   fx2_mul_exponent,
  output logic [LANES-1:0][23:0]  fx2_mul_significand1,
  output logic [LANES-1:0][23:0]  fx2_mul_significand2,
  output logic [LANES-1:0]        fx2_mul_sign,
  output logic [LANES-1:0]        fx2_result_is_inf,
  output logic [LANES-1:0]        fx2_result_is_nan
);

  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_CMP = 2'd3;

  // Shift the small significand right, folding every bit that falls off the
  // bottom into the sticky bit. Shifts past the full width leave only sticky.
  function automatic logic [26:0] align_small(input logic [26:0] sig,
                                              input logic [7:0]  shift);
    logic [26:0] shifted;
    logic [26:0] lost_mask;
    if (shift >= 8'd27) begin
      return {26'b0, |sig};
    end
    shifted   = sig >> shift;
    lost_mask = ~(27'h7ffffff << shift);
    return {shifted[26:1], shifted[0] | (|(sig & lost_mask))};
  endfunction

  // Clamp the signed product exponent into the biased 8-bit range:
  // overflow saturates to 255, underflow flushes to 0.
  function automatic logic [7:0] mul_exp_sat(input logic signed [9:0] sum);
    if (sum >= 10'sd255) begin
      return 8'd255;
    end else if (sum <= 10'sd0) begin
      return 8'd0;
    end
    return sum[7:0];
  endfunction

  logic                   vld_p1;
  logic [1:0]             op_p1;
  logic [LANES-1:0]       mask_p1;
  logic [1:0]             thread_p1;
  logic [LANES-1:0]       sign1_p1, sign2_p1;
  logic [LANES-1:0][7:0]  exp1_p1, exp2_p1;
  logic [LANES-1:0]       hid1_p1, hid2_p1;
  logic [LANES-1:0][22:0] frac1_p1, frac2_p1;
  logic [LANES-1:0]       zero1_p1, zero2_p1;
  logic [LANES-1:0]       inf1_p1, inf2_p1;
  logic [LANES-1:0]       nan1_p1, nan2_p1;

  logic [LANES-1:0][7:0]  add_exp_d;
  logic [LANES-1:0][26:0] sig_large_d, sig_small_d;
  logic [LANES-1:0]       logsub_d, res_sign_d;
  logic [LANES-1:0][7:0]  mul_exp_d;
  logic [LANES-1:0][23:0] mul_sig1_d, mul_sig2_d;
  logic [LANES-1:0]       mul_sign_d, is_inf_d, is_nan_d;

  // ---- stage 1: valid bit (only control state is reset here)
  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= of_instruction_valid;
  end

  // Stage 1 data: field split, hidden bit, effective exponent, classes.
  always_ff @(posedge clk) begin
    op_p1     <= of_op;
    mask_p1   <= of_mask_value;
    thread_p1 <= of_thread_idx;
    for (int i = 0; i < LANES; i++) begin
      sign1_p1[i] <= of_operand1[i][31];
      sign2_p1[i] <= of_operand2[i][31] ^ ((of_op == OP_SUB) || (of_op == OP_CMP));
      exp1_p1[i]  <= (of_operand1[i][30:23] == 8'd0) ? 8'd1 : of_operand1[i][30:23];
      exp2_p1[i]  <= (of_operand2[i][30:23] == 8'd0) ? 8'd1 : of_operand2[i][30:23];
      hid1_p1[i]  <= (of_operand1[i][30:23] != 8'd0);
      hid2_p1[i]  <= (of_operand2[i][30:23] != 8'd0);
      frac1_p1[i] <= of_operand1[i][22:0];
      frac2_p1[i] <= of_operand2[i][22:0];
      zero1_p1[i] <= (of_operand1[i][30:0] == 31'd0);
      zero2_p1[i] <= (of_operand2[i][30:0] == 31'd0);
      inf1_p1[i]  <= (of_operand1[i][30:23] == 8'hff) && (of_operand1[i][22:0] == 23'd0);
      inf2_p1[i]  <= (of_operand2[i][30:23] == 8'hff) && (of_operand2[i][22:0] == 23'd0);
      nan1_p1[i]  <= (of_operand1[i][30:23] == 8'hff) && (of_operand1[i][22:0] != 23'd0);
      nan2_p1[i]  <= (of_operand2[i][30:23] == 8'hff) && (of_operand2[i][22:0] != 23'd0);
    end
  end

  // ---- stage 2: add-path ordering/alignment, multiply exponent, special flags
  always_comb begin
    add_exp_d   = '0;
    sig_large_d = '0;
    sig_small_d = '0;
    logsub_d    = '0;
    res_sign_d  = '0;
    mul_exp_d   = '0;
    mul_sig1_d  = '0;
    mul_sig2_d  = '0;
    mul_sign_d  = '0;
    is_inf_d    = '0;
    is_nan_d    = '0;
    for (int i = 0; i < LANES; i++) begin : lane
      logic [31:0]        mag1, mag2;
      logic               swap;
      logic [7:0]         exp_l, exp_s;
      logic [23:0]        sig1, sig2, sig_l, sig_s;
      logic               sign_l, logsub;
      logic signed [9:0]  sum;
      logic               ovf, unf, any_zero;
      logic               nan_add, nan_mul;

      sig1   = {hid1_p1[i], frac1_p1[i]};
      sig2   = {hid2_p1[i], frac2_p1[i]};
      mag1   = {exp1_p1[i], sig1};
      mag2   = {exp2_p1[i], sig2};
      swap   = (mag2 > mag1);
      exp_l  = swap ? exp2_p1[i] : exp1_p1[i];
      exp_s  = swap ? exp1_p1[i] : exp2_p1[i];
      sig_l  = swap ? sig2 : sig1;
      sig_s  = swap ? sig1 : sig2;
      sign_l = swap ? sign2_p1[i] : sign1_p1[i];
      logsub = sign1_p1[i] ^ sign2_p1[i];

      add_exp_d[i]   = exp_l;
      sig_large_d[i] = {sig_l, 3'b000};
      sig_small_d[i] = align_small({sig_s, 3'b000}, exp_l - exp_s);
      logsub_d[i]    = logsub;
      res_sign_d[i]  = ((mag1 == mag2) && logsub) ? 1'b0 : sign_l;

      sum      = $signed({2'b00, exp1_p1[i]}) + $signed({2'b00, exp2_p1[i]}) - 10'sd127;
      ovf      = (sum >= 10'sd255);
      unf      = (sum <= 10'sd0);
      any_zero = zero1_p1[i] | zero2_p1[i];

      mul_exp_d[i]  = any_zero ? 8'd0 : mul_exp_sat(sum);
      mul_sig1_d[i] = (unf || any_zero) ? 24'd0 : sig1;
      mul_sig2_d[i] = (unf || any_zero) ? 24'd0 : sig2;
      mul_sign_d[i] = sign1_p1[i] ^ sign2_p1[i];

      nan_add = nan1_p1[i] | nan2_p1[i] | (inf1_p1[i] & inf2_p1[i] & logsub);
      nan_mul = nan1_p1[i] | nan2_p1[i] | (inf1_p1[i] & zero2_p1[i]) | (inf2_p1[i] & zero1_p1[i]);
      if (op_p1 == OP_MUL) begin
        is_nan_d[i] = nan_mul;
        is_inf_d[i] = (inf1_p1[i] | inf2_p1[i] | ovf) & ~nan_mul;
      end else begin
        is_nan_d[i] = nan_add;
        is_inf_d[i] = (inf1_p1[i] | inf2_p1[i]) & ~nan_add;
      end
    end
  end

  // Stage 2 output registers; every output reads zero out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fx2_instruction_valid     <= 1'b0;
      fx2_op                    <= '0;
      fx2_mask_value            <= '0;
      fx2_thread_idx            <= '0;
      fx2_add_exponent          <= '0;
      fx2_add_significand_large <= '0;
      fx2_add_significand_small <= '0;
      fx2_logical_subtract      <= '0;
      fx2_add_result_sign       <= '0;
      fx2_mul_exponent          <= '0;
      fx2_mul_significand1      <= '0;
      fx2_mul_significand2      <= '0;
      fx2_mul_sign              <= '0;
      fx2_result_is_inf         <= '0;
      fx2_result_is_nan         <= '0;
    end else begin
      fx2_instruction_valid     <= vld_p1;
      fx2_op                    <= op_p1;
      fx2_mask_value            <= mask_p1;
      fx2_thread_idx            <= thread_p1;
      fx2_add_exponent          <= add_exp_d;
      fx2_add_significand_large <= sig_large_d;
      fx2_add_significand_small <= sig_small_d;
      fx2_logical_subtract      <= logsub_d;
      fx2_add_result_sign       <= res_sign_d;
      fx2_mul_exponent          <= mul_exp_d;
      fx2_mul_significand1      <= mul_sig1_d;
      fx2_mul_significand2      <= mul_sig2_d;
      fx2_mul_sign              <= mul_sign_d;
      fx2_result_is_inf         <= is_inf_d;
      fx2_result_is_nan         <= is_nan_d;
    end
  end

endmodule

// File: tb/tb_fp_unpack_stage.sv
// Directed bench for fp_unpack_stage: hand-computed vectors for the add,
// subtract and multiply paths, special values, streaming and mid-flight reset.
module tb_fp_unpack_stage;
  localparam int LANES = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   of_instruction_valid;
  logic [1:0]             of_op;
  logic [LANES-1:0][31:0] of_operand1, of_operand2;
  logic [LANES-1:0]       of_mask_value;
  logic [1:0]             of_thread_idx;
  logic                   fx2_instruction_valid;
  logic [1:0]             fx2_op;
  logic [LANES-1:0]       fx2_mask_value;
  logic [1:0]             fx2_thread_idx;
  logic [LANES-1:0][7:0]  fx2_add_exponent;
  logic [LANES-1:0][26:0] fx2_add_significand_large, fx2_add_significand_small;
  logic [LANES-1:0]       fx2_logical_subtract, fx2_add_result_sign;
  logic [LANES-1:0][7:0]  fx2_mul_exponent;
  logic [LANES-1:0][23:0] fx2_mul_significand1, fx2_mul_significand2;
  logic [LANES-1:0]       fx2_mul_sign, fx2_result_is_inf, fx2_result_is_nan;

  int checks   = 0;
  int failures = 0;

  logic [1:0]  s_op  [5];
  logic [31:0] s_a   [5];
  logic [31:0] s_b   [5];
  logic [31:0] s_exp [5];
  logic [31:0] s_sml [5];

  always #5 clk = ~clk;

  fp_unpack_stage #(.LANES(LANES)) dut (
    .clk(clk), .reset(reset),
    .of_instruction_valid(of_instruction_valid), .of_op(of_op),
    .of_operand1(of_operand1), .of_operand2(of_operand2),
    .of_mask_value(of_mask_value), .of_thread_idx(of_thread_idx),
    .fx2_instruction_valid(fx2_instruction_valid), .fx2_op(fx2_op),
    .fx2_mask_value(fx2_mask_value), .fx2_thread_idx(fx2_thread_idx),
    .fx2_add_exponent(fx2_add_exponent),
    .fx2_add_significand_large(fx2_add_significand_large),
    .fx2_add_significand_small(fx2_add_significand_small),
    .fx2_logical_subtract(fx2_logical_subtract),
    .fx2_add_result_sign(fx2_add_result_sign),
    .fx2_mul_exponent(fx2_mul_exponent),
    .fx2_mul_significand1(fx2_mul_significand1),
    .fx2_mul_significand2(fx2_mul_significand2),
    .fx2_mul_sign(fx2_mul_sign),
    .fx2_result_is_inf(fx2_result_is_inf),
    .fx2_result_is_nan(fx2_result_is_nan)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    of_instruction_valid = 1'b1;
    of_op = op;
    for (int i = 0; i < LANES; i++) begin
      of_operand1[i] = a;
      of_operand2[i] = b;
    end
  endtask

  // Issue one instruction, then wait the two-cycle latency and sample.
  task automatic run_one(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(op, a, b);
    @(posedge clk); #1;
    of_instruction_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    of_instruction_valid = 1'b0;
    of_op = 2'd0;
    of_operand1 = '0;
    of_operand2 = '0;
    of_mask_value = 16'hA5A5;
    of_thread_idx = 2'd2;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(fx2_instruction_valid), 32'h0);
    check("rst_mask", 32'(fx2_mask_value), 32'h0);
    check("rst_add_exp", 32'(fx2_add_exponent[0]), 32'h0);
    check("rst_nan", 32'(fx2_result_is_nan), 32'h0);
    reset = 1'b0;

    // 1.0 + 1.0
    run_one(2'd0, 32'h3f800000, 32'h3f800000);
    check("add11_valid", 32'(fx2_instruction_valid), 32'h1);
    check("add11_mask", 32'(fx2_mask_value), 32'hA5A5);
    check("add11_thread", 32'(fx2_thread_idx), 32'h2);
    check("add11_exp", 32'(fx2_add_exponent[0]), 32'd127);
    check("add11_large", 32'(fx2_add_significand_large[0]), 32'h4000000);
    check("add11_small", 32'(fx2_add_significand_small[15]), 32'h4000000);
    check("add11_logsub", 32'(fx2_logical_subtract[0]), 32'h0);
    check("add11_sign", 32'(fx2_add_result_sign[0]), 32'h0);
    check("add11_inf", 32'(fx2_result_is_inf), 32'h0);
    check("add11_nan", 32'(fx2_result_is_nan), 32'h0);

    // 1.0 - 1.0
    run_one(2'd1, 32'h3f800000, 32'h3f800000);
    check("sub11_logsub", 32'(fx2_logical_subtract[0]), 32'h1);
    check("sub11_sign", 32'(fx2_add_result_sign[0]), 32'h0);
    check("sub11_large", 32'(fx2_add_significand_large[0]), 32'h4000000);
    check("sub11_small", 32'(fx2_add_significand_small[0]), 32'h4000000);

    // 2^24 + 1.0 : guard bit only
    run_one(2'd0, 32'h4b800000, 32'h3f800000);
    check("add24_exp", 32'(fx2_add_exponent[0]), 32'd151);
    check("add24_small", 32'(fx2_add_significand_small[0]), 32'h0000004);

    // 2^30 + 1.0 : shift past width, sticky only
    run_one(2'd0, 32'h4e800000, 32'h3f800000);
    check("add30_exp", 32'(fx2_add_exponent[0]), 32'd157);
    check("add30_small", 32'(fx2_add_significand_small[0]), 32'h0000001);

    // 1.0 + (-2^24) : operand 2 larger, swap and take its sign
    run_one(2'd0, 32'h3f800000, 32'hcb800000);
    check("swap_exp", 32'(fx2_add_exponent[0]), 32'd151);
    check("swap_small", 32'(fx2_add_significand_small[0]), 32'h0000004);
    check("swap_logsub", 32'(fx2_logical_subtract[0]), 32'h1);
    check("swap_sign", 32'(fx2_add_result_sign[0]), 32'h1);

    // 1.5 * 2.0
    run_one(2'd2, 32'h3fc00000, 32'h40000000);
    check("mul_exp", 32'(fx2_mul_exponent[0]), 32'd128);
    check("mul_sig1", 32'(fx2_mul_significand1[0]), 32'hC00000);
    check("mul_sig2", 32'(fx2_mul_significand2[0]), 32'h800000);
    check("mul_sign", 32'(fx2_mul_sign[0]), 32'h0);
    check("mul_inf", 32'(fx2_result_is_inf[0]), 32'h0);

    // overflow: 2^127 * 2^127
    run_one(2'd2, 32'h7f000000, 32'h7f000000);
    check("mulovf_inf", 32'(fx2_result_is_inf[0]), 32'h1);
    check("mulovf_exp", 32'(fx2_mul_exponent[0]), 32'd255);
    check("mulovf_nan", 32'(fx2_result_is_nan[0]), 32'h0);

    // underflow: 2^-126 * 2^-126 flushes to zero
    run_one(2'd2, 32'h00800000, 32'h00800000);
    check("mulunf_exp", 32'(fx2_mul_exponent[0]), 32'd0);
    check("mulunf_sig1", 32'(fx2_mul_significand1[0]), 32'h0);

    // +inf + -inf
    run_one(2'd0, 32'h7f800000, 32'hff800000);
    check("infinf_nan", 32'(fx2_result_is_nan[0]), 32'h1);
    check("infinf_inf", 32'(fx2_result_is_inf[0]), 32'h0);

    // inf * 0
    run_one(2'd2, 32'h7f800000, 32'h00000000);
    check("infzero_nan", 32'(fx2_result_is_nan[0]), 32'h1);

    // qNaN + 1.0
    run_one(2'd0, 32'h7fc00000, 32'h3f800000);
    check("qnan_nan", 32'(fx2_result_is_nan[0]), 32'h1);

    // +inf + 1.0
    run_one(2'd0, 32'h7f800000, 32'h3f800000);
    check("inf1_inf", 32'(fx2_result_is_inf[0]), 32'h1);
    check("inf1_nan", 32'(fx2_result_is_nan[0]), 32'h0);
    check("inf1_sign", 32'(fx2_add_result_sign[0]), 32'h0);

    // Back-to-back stream, then reset while instructions are in flight.
    s_op[0] = 2'd0; s_a[0] = 32'h3f800000; s_b[0] = 32'h3f800000; s_exp[0] = 32'd127; s_sml[0] = 32'h4000000;
    s_op[1] = 2'd2; s_a[1] = 32'h3fc00000; s_b[1] = 32'h40000000; s_exp[1] = 32'd128; s_sml[1] = 32'h3000000;
    s_op[2] = 2'd0; s_a[2] = 32'h4b800000; s_b[2] = 32'h3f800000; s_exp[2] = 32'd151; s_sml[2] = 32'h0000004;
    s_op[3] = 2'd1; s_a[3] = 32'h4e800000; s_b[3] = 32'h3f800000; s_exp[3] = 32'd157; s_sml[3] = 32'h0000001;
    s_op[4] = 2'd2; s_a[4] = 32'h7f000000; s_b[4] = 32'h7f000000; s_exp[4] = 32'd254; s_sml[4] = 32'h4000000;
    of_mask_value = 16'h00FF;
    for (int k = 0; k < 5; k++) begin
      drive(s_op[k], s_a[k], s_b[k]);
      @(posedge clk); #1;
      if (k >= 1) begin
        check($sformatf("stream%0d_valid", k - 1), 32'(fx2_instruction_valid), 32'h1);
        check($sformatf("stream%0d_op", k - 1), 32'(fx2_op), 32'(s_op[k - 1]));
        check($sformatf("stream%0d_exp", k - 1), 32'(fx2_add_exponent[0]), s_exp[k - 1]);
        check($sformatf("stream%0d_small", k - 1), 32'(fx2_add_significand_small[0]), s_sml[k - 1]);
      end
    end

    // I4 sits in stage 1; a sixth instruction is offered alongside reset.
    drive(2'd0, 32'h3f800000, 32'h3f800000);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    of_instruction_valid = 1'b0;
    check("midrst_valid", 32'(fx2_instruction_valid), 32'h0);
    check("midrst_op", 32'(fx2_op), 32'h0);
    check("midrst_mask", 32'(fx2_mask_value), 32'h0);
    check("midrst_add_exp", 32'(fx2_add_exponent[0]), 32'h0);
    check("midrst_small", 32'(fx2_add_significand_small[0]), 32'h0);
    check("midrst_mul_exp", 32'(fx2_mul_exponent[0]), 32'h0);
    check("midrst_inf", 32'(fx2_result_is_inf), 32'h0);
    @(posedge clk); #1;
    check("midrst_discard", 32'(fx2_instruction_valid), 32'h0);

    // First instruction after reset: exactly two cycles of latency.
    drive(2'd2, 32'h3fc00000, 32'h40000000);
    @(posedge clk); #1;
    of_instruction_valid = 1'b0;
    check("post_lat1_valid", 32'(fx2_instruction_valid), 32'h0);
    @(posedge clk); #1;
    check("post_valid", 32'(fx2_instruction_valid), 32'h1);
    check("post_op", 32'(fx2_op), 32'h2);
    check("post_mask", 32'(fx2_mask_value), 32'h00FF);
    check("post_mul_exp", 32'(fx2_mul_exponent[0]), 32'd128);
    check("post_mul_sig1", 32'(fx2_mul_significand1[0]), 32'hC00000);
    @(posedge clk); #1;
    check("post_valid_drop", 32'(fx2_instruction_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
